uart_rx_oversampled: RTL and testbench

//  UART receiver: the stage downstream of the UART transmitter, consuming its SerialOut line.

---
 rtl/uart_rx_oversampled.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, 3-sample majority vote per bit at OVERSAMPLE x baud, byte buffer with DataReady/ReadAck.
// DataReady rises 9*OVERSAMPLE+MID+2 edges after IDLE sees the start edge; an unread byte blocks new stores (Overrun).
module uart_rx_oversampled #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic       BitClk,
  input  logic       Reset,
  input  logic       SerialIn,
  input  logic       ReadAck,
  output logic [0:7] DataOut,
  output logic       DataReady,
  output logic       FramingErr,
  output logic       Overrun,
  output logic       RxBusy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CNT_W-1:0] C_MID_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] C_MID    = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] C_MID_P1 = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(OVERSAMPLE - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitn;
  logic [0:7]       r_shift;
  logic             r_vote_a;
  logic             r_vote_b;
  logic             r_armed;
  logic [0:7]       r_data;
  logic             r_ready;
  logic             r_ferr;
  logic             r_ovr;

  logic w_rx;
  logic w_vote;
  logic w_vote_now;
  logic w_bit_end;
  logic w_stop_vote;

  assign w_rx        = r_sync2;
  assign w_vote      = (r_vote_a & r_vote_b) | (r_vote_a & w_rx) | (r_vote_b & w_rx);
  assign w_vote_now  = (r_cnt == C_MID_P1);
  assign w_bit_end   = (r_cnt == C_LAST);
  assign w_stop_vote = (r_state == S_STOP) && w_vote_now;

  // Idle-high reset value keeps the line from looking like a start bit.
  always_ff @(posedge BitClk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= SerialIn;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge BitClk or posedge Reset) begin
    if (Reset) begin
      r_vote_a <= 1'b0;
      r_vote_b <= 1'b0;
    end else begin
      if (r_cnt == C_MID_M1) r_vote_a <= w_rx;
      if (r_cnt == C_MID)    r_vote_b <= w_rx;
    end
  end

  always_ff @(posedge BitClk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_armed <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_rx) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_vote_now && w_vote) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_bit_end) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_bitn  <= '0;
          end
        end
        S_DATA: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_vote_now) r_shift[r_bitn] <= w_vote;
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bitn == 3'd7) r_state <= S_STOP;
            else                r_bitn  <= r_bitn + 3'd1;
          end
        end
        default: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Leave at the stop-bit vote so a back-to-back start edge is never missed.
          if (w_vote_now) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (!w_vote) r_armed <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge BitClk or posedge Reset) begin
    if (Reset) begin
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (ReadAck && r_ready) begin
        r_ready <= 1'b0;
        r_ferr  <= 1'b0;
        r_ovr   <= 1'b0;
      end else if (ReadAck) begin
        r_ferr <= 1'b0;
      end
      // A store in the same cycle as ReadAck overrides the clear.
      if (w_stop_vote) begin
        if (w_vote) begin
          if (!r_ready || ReadAck) begin
            r_data  <= r_shift;
            r_ready <= 1'b1;
          end else begin
            r_ovr <= 1'b1;
          end
        end else begin
          r_ferr <= 1'b1;
        end
      end
    end
  end

  assign DataOut    = r_data;
  assign DataReady  = r_ready;
  assign FramingErr = r_ferr;
  assign Overrun    = r_ovr;
  assign RxBusy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Randomized frame stimulus against a frame-level model of the receiver's byte buffer and flags.
module tb_uart_rx_oversampled;
  localparam int OS  = 16;
  localparam int LAT = 3 + 9 * OS + OS / 2 + 2;  // line drive -> DataReady (2 sync flops + IDLE edge)

  logic       BitClk = 1'b0;
  logic       Reset;
  logic       SerialIn;
  logic       ReadAck;
  logic [0:7] DataOut;
  logic       DataReady;
  logic       FramingErr;
  logic       Overrun;
  logic       RxBusy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rise_cyc = -1;
  logic dr_prev = 1'b0;

  logic [7:0] m_data;
  logic       m_ready, m_ferr, m_ovr;

  uart_rx_oversampled #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
    .BitClk    (BitClk),
    .Reset     (Reset),
    .SerialIn  (SerialIn),
    .ReadAck   (ReadAck),
    .DataOut   (DataOut),
    .DataReady (DataReady),
    .FramingErr(FramingErr),
    .Overrun   (Overrun),
    .RxBusy    (RxBusy)
  );

  always #5 BitClk = ~BitClk;
  always @(posedge BitClk) cyc++;
  always @(negedge BitClk) begin
    if (DataReady && !dr_prev) rise_cyc = cyc;
    dr_prev = DataReady;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/data"},  32'(DataOut),    32'(m_data));
    chk({tag, "/ready"}, 32'(DataReady),  32'(m_ready));
    chk({tag, "/ferr"},  32'(FramingErr), 32'(m_ferr));
    chk({tag, "/ovr"},   32'(Overrun),    32'(m_ovr));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge BitClk); #1;
      SerialIn = 1'b1;
    end
  endtask

  task automatic do_ack(input string tag);
    @(posedge BitClk); #1 ReadAck = 1'b1;
    @(posedge BitClk); #1 ReadAck = 1'b0;
    if (m_ready) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
    m_ferr = 1'b0;
    @(negedge BitClk);
    check_all(tag);
  endtask

  // One full 10-bit frame; noisy adds single-clock spikes inside some data bits.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic stopv,
                            input bit noisy, input bit ack_store, output int t0);
    logic [9:0] frame;
    int np[8];
    int s;
    logic v;
    frame = {1'b0, d, stopv};
    t0 = 0;
    for (int k = 0; k < 8; k++)
      np[k] = (noisy && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, OS - 1)) : -1;
    for (int i = 0; i < 10 * OS; i++) begin
      @(posedge BitClk); #1;
      if (i == 0) t0 = cyc;
      s = i / OS;
      v = frame[9 - s];
      if (s >= 1 && s <= 8 && (i % OS) == np[s - 1]) v = ~v;
      SerialIn = v;
      ReadAck  = ack_store && (i == LAT - 1);
    end
    ReadAck = 1'b0;
    if (stopv) begin
      if (ack_store) begin
        m_ferr = 1'b0;
        if (m_ready) m_ovr = 1'b0;
        m_data  = d;
        m_ready = 1'b1;
      end else if (m_ready) begin
        m_ovr = 1'b1;
      end else begin
        m_data  = d;
        m_ready = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
    end
    @(negedge BitClk);
    check_all(tag);
  endtask

  initial begin
    int t0;
    bit busy_seen;
    bit bad_stop;
    logic [7:0] rd;
    Reset = 1'b1; SerialIn = 1'b1; ReadAck = 1'b0;
    m_data = '0; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    #23;
    check_all("reset");
    chk("reset/busy", 32'(RxBusy), 0);
    @(posedge BitClk); #1 Reset = 1'b0;
    idle(10);

    // Basic frame and latency
    rise_cyc = -1;
    send_frame("t1", 8'b10010010, 1'b1, 0, 0, t0);
    chk("t1/lat", 32'(rise_cyc - t0), 32'(LAT));
    do_ack("t1ack");

    // Short glitch on the line
    idle(5);
    @(posedge BitClk); #1 SerialIn = 1'b0;
    @(posedge BitClk);
    @(posedge BitClk);
    @(posedge BitClk); #1 SerialIn = 1'b1;
    @(negedge BitClk);
    chk("t2/busy_on", 32'(RxBusy), 1);
    idle(20);
    @(negedge BitClk);
    chk("t2/busy_off", 32'(RxBusy), 0);
    chk("t2/ready", 32'(DataReady), 32'(m_ready));

    // Back-to-back frames, overrun
    send_frame("t3a", 8'hA5, 1'b1, 0, 0, t0);
    send_frame("t3b", 8'h3C, 1'b1, 0, 0, t0);
    do_ack("t3ack");

    // Framing error, line held low, then a good frame
    idle(4);
    send_frame("t4bad", 8'hC3, 1'b0, 0, 0, t0);
    busy_seen = 0;
    repeat (40) begin
      @(posedge BitClk); #1 SerialIn = 1'b0;
      @(negedge BitClk);
      if (RxBusy) busy_seen = 1;
    end
    chk("t4/no_start", 32'(busy_seen), 0);
    idle(8);
    send_frame("t4good", 8'h55, 1'b1, 1, 0, t0);
    do_ack("t4ack");

    // ReadAck coinciding with the store
    send_frame("t5a", 8'h11, 1'b1, 0, 0, t0);
    send_frame("t5b", 8'h7E, 1'b1, 0, 1, t0);

    // Reset in the middle of the data bits
    for (int i = 0; i < 4 * OS; i++) begin
      @(posedge BitClk); #1;
      SerialIn = 1'b0;
    end
    chk("t6/busy_pre", 32'(RxBusy), 1);
    #2 Reset = 1'b1;
    #1;
    m_data = '0; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    check_all("t6rst");
    chk("t6rst/busy", 32'(RxBusy), 0);
    SerialIn = 1'b1;
    @(posedge BitClk); #1 Reset = 1'b0;
    idle(10);
    send_frame("t6", 8'hF0, 1'b1, 1, 0, t0);

    // Randomized frames
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 2) == 0) do_ack("rnd_ack");
      rd = 8'($urandom);
      bad_stop = ($urandom_range(0, 5) == 0);
      send_frame("rnd", rd, !bad_stop, 1, 0, t0);
      idle(bad_stop ? int'($urandom_range(2, 20)) : int'($urandom_range(0, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
